// File: rtl/xmm_write_arbiter.sv
// Round-robin write-back arbiter for the XMM register file with a registered write port.
// Define XMM_WB_SCOREBOARD_EN to compile in the pending-write scoreboard and reserve_conflict.
module xmm_write_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*5-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      reserve_valid,
    input  logic [4:0]                reserve_addr,
    output logic [31:0]               busy,
    output logic                      reserve_conflict,
    output logic                      rf_should_write,
    output logic [4:0]                rf_write_addr,
    output logic [DATA_W-1:0]         rf_write_data
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] One = NUM_REQ'(1);

    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [2*NUM_REQ-1:0] valid_dbl, valid_rot, grant_dbl;
    logic [NUM_REQ-1:0]   valid_rot_n, first_rot;
    logic                 xfer;
    logic [4:0]           sel_addr;
    logic [DATA_W-1:0]    sel_data;

    // Rotate so ptr sits at bit 0, isolate the lowest valid bit, rotate back.
    assign valid_dbl   = {req_valid, req_valid};
    assign valid_rot   = valid_dbl >> ptr_q;
    assign valid_rot_n = valid_rot[NUM_REQ-1:0];
    assign first_rot   = valid_rot_n & (~valid_rot_n + One);
    assign grant_dbl   = {first_rot, first_rot} << ptr_q;
    assign req_ready   = grant_dbl[2*NUM_REQ-1:NUM_REQ];

    always_comb begin
        xfer     = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        ptr_d    = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                xfer     = 1'b1;
                sel_addr = req_addr[5*i +: 5];
                sel_data = req_data[DATA_W*i +: DATA_W];
                ptr_d    = PtrW'((i + 1) % NUM_REQ);
            end
        end
    end

    // Writes to register 0 are acknowledged but never reach the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q           <= '0;
            rf_should_write <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            ptr_q           <= ptr_d;
            rf_should_write <= xfer && (sel_addr != 5'd0);
            if (xfer && (sel_addr != 5'd0)) begin
                rf_write_addr <= sel_addr;
                rf_write_data <= sel_data;
            end
        end
    end

`ifdef XMM_WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;
    logic        conflict_q, conflict_d;
    logic        res_hit, clr_hit;

    always_comb begin
        busy_d     = busy_q;
        res_hit    = reserve_valid && (reserve_addr != 5'd0);
        clr_hit    = rf_should_write && (rf_write_addr == reserve_addr);
        conflict_d = conflict_q | (res_hit & busy_q[reserve_addr] & ~clr_hit);
        if (rf_should_write) begin
            busy_d[rf_write_addr] = 1'b0;
        end
        // Set after clear so a same-edge re-reserve keeps the register busy.
        if (res_hit) begin
            busy_d[reserve_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy             = busy_q;
    assign reserve_conflict = conflict_q;
`else
    logic unused_reserve;
    assign unused_reserve   = ^{reserve_valid, reserve_addr};
    assign busy             = '0;
    assign reserve_conflict = 1'b0;
`endif

endmodule
